// File: rtl/sparc_fetch_stage.sv
// SPARC fetch stage: owns PC/nPC, addresses instruction memory and holds the IF/ID register.
// Handles delayed control transfer (branch in ID, jmpl in EX), delay-slot annul and hazard stalls.
module sparc_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0100_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_Hazard_Stall,
  input  logic        ID_Branch_Taken,
  input  logic [31:0] ID_Branch_Target,
  input  logic        ID_Annul_Slot,
  input  logic        EX_Jumpl_Taken,
  input  logic [31:0] EX_Jumpl_Target,
  input  logic [31:0] IM_Instr,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_nPC,
  output logic [31:0] ID_Instr,
  output logic [31:0] ID_PC,
  output logic        ID_Valid
);

  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_valid;
  logic [31:0] branch_tgt;
  logic [31:0] jumpl_tgt;

  // Instruction words are word aligned, so the low two target bits are dropped.
  assign branch_tgt = {ID_Branch_Target[31:2], 2'b00};
  assign jumpl_tgt  = {EX_Jumpl_Target[31:2], 2'b00};

  // A jmpl redirect beats a stall and any branch/annul in ID (DCTI couple).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      npc      <= RESET_PC + 32'd4;
      id_instr <= NOP_INSTR;
      id_pc    <= 32'd0;
      id_valid <= 1'b0;
    end else if (EX_Jumpl_Taken) begin
      pc       <= jumpl_tgt;
      npc      <= jumpl_tgt + 32'd4;
      id_instr <= NOP_INSTR;
      id_pc    <= pc;
      id_valid <= 1'b0;
    end else if (!ID_Hazard_Stall) begin
      if (ID_Branch_Taken) begin
        pc  <= branch_tgt;
        npc <= branch_tgt + 32'd4;
      end else begin
        pc  <= npc;
        npc <= npc + 32'd4;
      end
      id_pc <= pc;
      if (ID_Annul_Slot) begin
        id_instr <= NOP_INSTR;
        id_valid <= 1'b0;
      end else begin
        id_instr <= IM_Instr;
        id_valid <= 1'b1;
      end
    end
  end

  assign IF_PC    = pc;
  assign IF_nPC   = npc;
  assign ID_Instr = id_instr;
  assign ID_PC    = id_pc;
  assign ID_Valid = id_valid;

endmodule

// File: tb/tb_sparc_fetch_stage.sv
// Self-checking bench for sparc_fetch_stage: table-driven vectors checked through a scoreboard queue,
// plus hand-written reset sequences.
module tb_sparc_fetch_stage;

  localparam logic [31:0] NOP = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_Hazard_Stall;
  logic        ID_Branch_Taken;
  logic [31:0] ID_Branch_Target;
  logic        ID_Annul_Slot;
  logic        EX_Jumpl_Taken;
  logic [31:0] EX_Jumpl_Target;
  logic [31:0] IM_Instr;
  logic [31:0] IF_PC;
  logic [31:0] IF_nPC;
  logic [31:0] ID_Instr;
  logic [31:0] ID_PC;
  logic        ID_Valid;

  typedef struct {
    logic        stall, taken, annul, jumpl;
    logic [31:0] btgt, jtgt;
    logic [31:0] e_pc, e_npc, e_idpc;
    logic        e_valid, ck_idpc;
  } vec_t;

  typedef struct {
    logic [31:0] pc, npc, idpc;
    logic        valid, ck_idpc;
    int          tag;
  } exp_t;

  vec_t vecs[22];
  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  sparc_fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .ID_Hazard_Stall  (ID_Hazard_Stall),
    .ID_Branch_Taken  (ID_Branch_Taken),
    .ID_Branch_Target (ID_Branch_Target),
    .ID_Annul_Slot    (ID_Annul_Slot),
    .EX_Jumpl_Taken   (EX_Jumpl_Taken),
    .EX_Jumpl_Target  (EX_Jumpl_Target),
    .IM_Instr         (IM_Instr),
    .IF_PC            (IF_PC),
    .IF_nPC           (IF_nPC),
    .ID_Instr         (ID_Instr),
    .ID_PC            (ID_PC),
    .ID_Valid         (ID_Valid)
  );

  always #5 clk = ~clk;

  // Instruction memory contents are a fixed scramble of the address, so ID_Instr is traceable.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign IM_Instr = mem(IF_PC);

  function automatic vec_t mk(input logic stall, taken, annul, jumpl,
                              input logic [31:0] btgt, jtgt, e_pc, e_npc, e_idpc,
                              input logic e_valid, ck_idpc);
    vec_t v;
    v.stall = stall; v.taken = taken; v.annul = annul; v.jumpl = jumpl;
    v.btgt = btgt; v.jtgt = jtgt;
    v.e_pc = e_pc; v.e_npc = e_npc; v.e_idpc = e_idpc;
    v.e_valid = e_valid; v.ck_idpc = ck_idpc;
    return v;
  endfunction

  task automatic check_val(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("[TB] FAIL %s step %0d: got %h, expected %h", nm, tag, act, exp);
    else
      passed++;
  endtask

  task automatic drive(input logic stall, taken, annul, jumpl, input logic [31:0] btgt, jtgt);
    ID_Hazard_Stall  = stall;
    ID_Branch_Taken  = taken;
    ID_Annul_Slot    = annul;
    EX_Jumpl_Taken   = jumpl;
    ID_Branch_Target = btgt;
    EX_Jumpl_Target  = jtgt;
  endtask

  task automatic push_exp(input logic [31:0] pc, npc, idpc, input logic valid, ck_idpc, input int tag);
    exp_t e;
    e.pc = pc; e.npc = npc; e.idpc = idpc; e.valid = valid; e.ck_idpc = ck_idpc; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input vec_t v, input int tag);
    drive(v.stall, v.taken, v.annul, v.jumpl, v.btgt, v.jtgt);
    push_exp(v.e_pc, v.e_npc, v.e_idpc, v.e_valid, v.ck_idpc, tag);
  endtask

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    check_val("IF_PC", e.tag, IF_PC, e.pc);
    check_val("IF_nPC", e.tag, IF_nPC, e.npc);
    check_val("ID_Valid", e.tag, {31'd0, ID_Valid}, {31'd0, e.valid});
    check_val("ID_Instr", e.tag, ID_Instr, e.valid ? mem(e.idpc) : NOP);
    if (e.ck_idpc) check_val("ID_PC", e.tag, ID_PC, e.idpc);
  endtask

  task automatic check_reset_state(input int tag);
    check_val("rst IF_PC", tag, IF_PC, 32'h0);
    check_val("rst IF_nPC", tag, IF_nPC, 32'h4);
    check_val("rst ID_Instr", tag, ID_Instr, NOP);
    check_val("rst ID_PC", tag, ID_PC, 32'h0);
    check_val("rst ID_Valid", tag, {31'd0, ID_Valid}, 32'h0);
  endtask

  initial begin
    // stall taken annul jumpl btgt jtgt | pc npc id_pc valid check_id_pc
    vecs[0]  = mk(0,0,0,0, 0, 0, 32'h04, 32'h08, 32'h00, 1, 1);
    vecs[1]  = mk(0,0,0,0, 0, 0, 32'h08, 32'h0C, 32'h04, 1, 1);
    vecs[2]  = mk(0,0,0,0, 0, 0, 32'h0C, 32'h10, 32'h08, 1, 1);
    vecs[3]  = mk(0,0,0,0, 0, 0, 32'h10, 32'h14, 32'h0C, 1, 1);
    vecs[4]  = mk(0,0,0,0, 0, 0, 32'h14, 32'h18, 32'h10, 1, 1);
    vecs[5]  = mk(0,1,0,0, 32'h40, 0, 32'h40, 32'h44, 32'h14, 1, 1);
    vecs[6]  = mk(0,0,0,0, 0, 0, 32'h44, 32'h48, 32'h40, 1, 1);
    vecs[7]  = mk(0,0,0,0, 0, 0, 32'h48, 32'h4C, 32'h44, 1, 1);
    vecs[8]  = mk(0,1,1,0, 32'h80, 0, 32'h80, 32'h84, 32'h48, 0, 1);
    vecs[9]  = mk(0,0,0,0, 0, 0, 32'h84, 32'h88, 32'h80, 1, 1);
    vecs[10] = mk(0,0,1,0, 0, 0, 32'h88, 32'h8C, 32'h84, 0, 1);
    vecs[11] = mk(0,0,0,0, 0, 0, 32'h8C, 32'h90, 32'h88, 1, 1);
    vecs[12] = mk(1,1,0,0, 32'h200, 0, 32'h8C, 32'h90, 32'h88, 1, 1);
    vecs[13] = mk(1,1,1,0, 32'h200, 0, 32'h8C, 32'h90, 32'h88, 1, 1);
    vecs[14] = mk(0,1,0,0, 32'h200, 0, 32'h200, 32'h204, 32'h8C, 1, 1);
    vecs[15] = mk(1,1,1,1, 32'h300, 32'h103, 32'h100, 32'h104, 32'h0, 0, 0);
    vecs[16] = mk(0,0,0,0, 0, 0, 32'h104, 32'h108, 32'h100, 1, 1);
    vecs[17] = mk(0,1,0,0, 32'h7, 0, 32'h04, 32'h08, 32'h104, 1, 1);
    vecs[18] = mk(0,1,0,0, 32'hFFFF_FFF8, 0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h04, 1, 1);
    vecs[19] = mk(0,0,0,0, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFF8, 1, 1);
    vecs[20] = mk(0,0,0,0, 0, 0, 32'h0, 32'h4, 32'hFFFF_FFFC, 1, 1);
    vecs[21] = mk(0,0,0,0, 0, 0, 32'h4, 32'h8, 32'h0, 1, 1);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_state(0);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      apply_stimulus(vecs[i], i + 1);
      @(posedge clk);
      #1;
      check_output();
    end

    // Mid-cycle async reset while a jmpl redirect and branch are pending.
    drive(0, 1, 1, 1, 32'h500, 32'h600);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state(100);
    @(posedge clk);
    #1;
    check_reset_state(101);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_exp(32'd4 * (i + 1), 32'd4 * (i + 2), 32'd4 * i, 1'b1, 1'b1, 200 + i);
      @(posedge clk);
      #1;
      check_output();
    end

    if (sb.size() != 0) begin
      total++;
      $display("[TB] FAIL scoreboard drain: got %0d entries, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
